// File: rtl/demorgan_sweep_checker_if.sv
// Bus between the De Morgan sweep checker and its surroundings.
// Carries the sweep control/status signals and the operand/result lines
// to and from the 2-bit De Morgan dataflow unit under check.
//   master : the sweep checker (drives operands and status, samples results)
//   slave  : the environment (drives start and the unit's results)
// Member names keep the checker's own port naming so both sides read alike.
interface demorgan_sweep_checker_if #(
  parameter int unsigned W     = 2,
  parameter int unsigned CNT_W = 8
);

  logic             start;
  logic [W-1:0]     a_o;
  logic [W-1:0]     b_o;
  logic [W-1:0]     cos_i;
  logic [W-1:0]     poc_i;
  logic [W-1:0]     cop_i;
  logic [W-1:0]     soc_i;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic             fail_valid;
  logic [W-1:0]     fail_a;
  logic [W-1:0]     fail_b;

  modport master (
    input  start,
    input  cos_i,
    input  poc_i,
    input  cop_i,
    input  soc_i,
    output a_o,
    output b_o,
    output busy,
    output done,
    output pass,
    output err_cnt,
    output fail_valid,
    output fail_a,
    output fail_b
  );

  modport slave (
    output start,
    output cos_i,
    output poc_i,
    output cop_i,
    output soc_i,
    input  a_o,
    input  b_o,
    input  busy,
    input  done,
    input  pass,
    input  err_cnt,
    input  fail_valid,
    input  fail_a,
    input  fail_b
  );

endinterface

// File: rtl/demorgan_sweep_checker.sv
// De Morgan sweep checker.
// Walks every operand pair {a,b} through the W-bit De Morgan dataflow unit,
// waits SETTLE cycles for the unit to settle, then checks both laws
// (cos==poc, cop==soc) and the golden values (cos==~(a|b), cop==~(a&b)).
// Reports pass/fail, a saturating count of failing vectors and the first
// failing vector.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : master side of demorgan_sweep_checker_if
//            start              - request a full sweep (sampled in idle only)
//            a_o, b_o           - registered operands to the unit
//            cos_i..soc_i       - unit results, sampled in the check state only
//            busy, done         - sweep in progress / one-cycle completion pulse
//            pass, err_cnt      - sweep verdict and saturating failure count
//            fail_valid/a/b     - first failing vector of the sweep
module demorgan_sweep_checker #(
  parameter int unsigned W      = 2,
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  demorgan_sweep_checker_if.master bus
);

  localparam int unsigned IdxW       = 2 * W;
  localparam int unsigned SettleLast = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam int unsigned WaitW      = (SettleLast > 0) ? $clog2(SettleLast + 1) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StApply,
    StWait,
    StCheck,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             fv_q, fv_d;
  logic [W-1:0]     fa_q, fa_d;
  logic [W-1:0]     fb_q, fb_d;
  logic             pass_q, pass_d;

  logic [W-1:0]     golden_nor;
  logic [W-1:0]     golden_nand;
  logic             mismatch;
  logic             idx_last;
  logic             err_sat;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      wait_q  <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      pass_q  <= pass_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Check logic: any law or golden-value violation on any bit fails the vector
  // ---------------------------------------------------------------------------
  always_comb begin
    golden_nor  = ~(a_q | b_q);
    golden_nand = ~(a_q & b_q);
    mismatch    = |((bus.cos_i ^ bus.poc_i) |
                    (bus.cop_i ^ bus.soc_i) |
                    (bus.cos_i ^ golden_nor) |
                    (bus.cop_i ^ golden_nand));
    idx_last    = (idx_q == {IdxW{1'b1}});
    err_sat     = (err_q == {CNT_W{1'b1}});
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StApply;
      StApply: state_d = (SETTLE > 0) ? StWait : StCheck;
      StWait:  if (wait_q == '0) state_d = StCheck;
      // The final vector always ends the sweep, so idx never wraps
      StCheck: state_d = idx_last ? StDone : StApply;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    idx_d  = idx_q;
    a_d    = a_q;
    b_d    = b_q;
    wait_d = wait_q;
    err_d  = err_q;
    fv_d   = fv_q;
    fa_d   = fa_q;
    fb_d   = fb_q;
    pass_d = pass_q;

    unique case (state_q)
      StIdle: begin
        a_d = '0;
        b_d = '0;
        // Results of the previous sweep stay visible until a new one is accepted
        if (bus.start) begin
          idx_d  = '0;
          err_d  = '0;
          fv_d   = 1'b0;
          fa_d   = '0;
          fb_d   = '0;
          pass_d = 1'b0;
        end
      end
      StApply: begin
        a_d    = idx_q[IdxW-1:W];
        b_d    = idx_q[W-1:0];
        wait_d = WaitW'(SettleLast);
      end
      StWait: begin
        if (wait_q != '0) wait_d = wait_q - WaitW'(1);
      end
      StCheck: begin
        if (mismatch) begin
          if (!err_sat) err_d = err_q + CNT_W'(1);
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = a_q;
            fb_d = b_q;
          end
        end
        if (idx_last) begin
          // Verdict is registered on the way into done so it shows with the pulse
          a_d    = '0;
          b_d    = '0;
          pass_d = (err_d == '0);
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        a_d = '0;
        b_d = '0;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.busy       = (state_q == StApply) || (state_q == StWait) || (state_q == StCheck);
    bus.done       = (state_q == StDone);
    bus.a_o        = a_q;
    bus.b_o        = b_q;
    bus.pass       = pass_q;
    bus.err_cnt    = err_q;
    bus.fail_valid = fv_q;
    bus.fail_a     = fa_q;
    bus.fail_b     = fb_q;
  end

endmodule

// File: tb/tb_demorgan_sweep_checker.sv
module tb_demorgan_sweep_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  demorgan_sweep_checker_if #(.W(2), .CNT_W(8)) bus1 ();
  demorgan_sweep_checker_if #(.W(2), .CNT_W(2)) bus2 ();

  demorgan_sweep_checker #(.W(2), .SETTLE(1), .CNT_W(8)) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  demorgan_sweep_checker #(.W(2), .SETTLE(0), .CNT_W(2)) u_dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );

  // Emulated unit: each output is (good & and_mask) | or_mask, 2 mask bits per output
  // in order cos, poc, cop, soc.
  logic [7:0] and_m = 8'hFF;
  logic [7:0] or_m  = 8'h00;

  function automatic int unit_out(int good, int k, logic [7:0] am, logic [7:0] om);
    int amk;
    int omk;
    amk = int'(am[2*k +: 2]);
    omk = int'(om[2*k +: 2]);
    return (good & amk) | omk;
  endfunction

  always_comb begin
    bus1.cos_i = 2'(unit_out(int'(~(bus1.a_o | bus1.b_o)), 0, and_m, or_m));
    bus1.poc_i = 2'(unit_out(int'(~bus1.a_o & ~bus1.b_o), 1, and_m, or_m));
    bus1.cop_i = 2'(unit_out(int'(~(bus1.a_o & bus1.b_o)), 2, and_m, or_m));
    bus1.soc_i = 2'(unit_out(int'(~bus1.a_o | ~bus1.b_o), 3, and_m, or_m));
  end

  assign bus2.cos_i = '0;
  assign bus2.poc_i = '0;
  assign bus2.cop_i = '0;
  assign bus2.soc_i = '0;

  typedef struct {
    int sc;
    int lat;
    int err;
    int pass;
    int fv;
    int fa;
    int fb;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  // Reference: apply the two laws and golden values to every pair, in sweep order.
  function automatic exp_t model(logic [7:0] am, logic [7:0] om, int cnt_max, int settle);
    exp_t e;
    e.sc = 0;
    e.err = 0;
    e.fv = 0;
    e.fa = 0;
    e.fb = 0;
    for (int v = 0; v < 16; v++) begin
      int a, b, nor_g, nand_g, cos, poc, cop, soc;
      a = v / 4;
      b = v % 4;
      nor_g  = 3 - (a | b);
      nand_g = 3 - (a & b);
      cos = unit_out(nor_g, 0, am, om);
      poc = unit_out((3 - a) & (3 - b), 1, am, om);
      cop = unit_out(nand_g, 2, am, om);
      soc = unit_out((3 - a) | (3 - b), 3, am, om);
      if (cos != poc || cop != soc || cos != nor_g || cop != nand_g) begin
        if (e.err < cnt_max) e.err++;
        if (e.fv == 0) begin
          e.fv = 1;
          e.fa = a;
          e.fb = b;
        end
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    e.lat = 16 * (settle + 2) + 1;
    return e;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor for the SETTLE=1 checker
  always @(negedge clk) begin
    if (rst_n) begin
      if (q1.size() > 0) begin
        int n;
        n = cyc - q1[0].sc;
        if (n >= 3 && n <= 48 && (n % 3) == 0) check("vector", {bus1.a_o, bus1.b_o}, n / 3 - 1);
        if (n == 1 || n == 48) check("busy_high", int'(bus1.busy), 1);
      end
      if (bus1.done) begin
        check("done_expected", int'(q1.size() > 0), 1);
        if (q1.size() > 0) begin
          exp_t e;
          e = q1.pop_front();
          check("done_latency", cyc - e.sc, e.lat);
          check("err_cnt", int'(bus1.err_cnt), e.err);
          check("pass", int'(bus1.pass), e.pass);
          check("fail_valid", int'(bus1.fail_valid), e.fv);
          check("fail_a", int'(bus1.fail_a), e.fa);
          check("fail_b", int'(bus1.fail_b), e.fb);
          check("busy_at_done", int'(bus1.busy), 0);
        end
      end
    end
  end

  // Monitor for the SETTLE=0, CNT_W=2 checker
  always @(negedge clk) begin
    if (rst_n && bus2.done) begin
      check("done2_expected", int'(q2.size() > 0), 1);
      if (q2.size() > 0) begin
        exp_t e;
        e = q2.pop_front();
        check("done2_latency", cyc - e.sc, e.lat);
        check("err_cnt2", int'(bus2.err_cnt), e.err);
        check("pass2", int'(bus2.pass), e.pass);
        check("fail_valid2", int'(bus2.fail_valid), e.fv);
        check("fail_a2", int'(bus2.fail_a), e.fa);
        check("fail_b2", int'(bus2.fail_b), e.fb);
      end
    end
  end

  task automatic run1(input logic [7:0] am, input logic [7:0] om, output exp_t e);
    @(negedge clk);
    and_m = am;
    or_m = om;
    bus1.start = 1'b1;
    e = model(am, om, 255, 1);
    e.sc = cyc;
    q1.push_back(e);
    @(negedge clk);
    bus1.start = 1'b0;
  endtask

  task automatic wait_idle1(int bound);
    int k;
    k = 0;
    while (q1.size() > 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (q1.size() > 0) begin
      check("timeout1", q1.size(), 0);
      q1.delete();
    end
  endtask

  task automatic check_reset1();
    check("rst_a_o", int'(bus1.a_o), 0);
    check("rst_b_o", int'(bus1.b_o), 0);
    check("rst_busy", int'(bus1.busy), 0);
    check("rst_done", int'(bus1.done), 0);
    check("rst_pass", int'(bus1.pass), 0);
    check("rst_err_cnt", int'(bus1.err_cnt), 0);
    check("rst_fail_valid", int'(bus1.fail_valid), 0);
    check("rst_fail_a", int'(bus1.fail_a), 0);
    check("rst_fail_b", int'(bus1.fail_b), 0);
  endtask

  initial begin
    exp_t e;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset1();
    check("rst_err_cnt2", int'(bus2.err_cnt), 0);
    rst_n = 1'b1;

    // Good unit; verdict must hold in idle afterwards
    run1(8'hFF, 8'h00, e);
    wait_idle1(200);
    repeat (5) @(negedge clk);
    check("hold_pass", int'(bus1.pass), e.pass);
    check("hold_err_cnt", int'(bus1.err_cnt), e.err);

    // poc_i[0] stuck at 0
    run1(8'hFB, 8'h00, e);
    wait_idle1(200);
    repeat (3) @(negedge clk);
    check("hold_fail_valid", int'(bus1.fail_valid), e.fv);

    // start during a sweep is ignored
    run1(8'hFF, 8'h00, e);
    repeat (8) @(negedge clk);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    wait_idle1(200);
    repeat (4) @(negedge clk);

    // Randomized faults
    for (int t = 0; t < 6; t++) begin
      logic [7:0] am, om;
      am = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      om = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      run1(am, om, e);
      wait_idle1(200);
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    // Asynchronous reset mid-sweep of a faulty run, then a fresh sweep
    run1(8'hFB, 8'h00, e);
    repeat ($urandom_range(15, 40)) @(negedge clk);
    #($urandom_range(1, 4));
    rst_n = 1'b0;
    q1.delete();
    #1;
    check_reset1();
    @(negedge clk);
    rst_n = 1'b1;
    run1(8'hF7, 8'h00, e);
    wait_idle1(200);

    // SETTLE=0, CNT_W=2, all unit outputs tied low
    @(negedge clk);
    bus2.start = 1'b1;
    e = model(8'h00, 8'h00, 3, 0);
    e.sc = cyc;
    q2.push_back(e);
    @(negedge clk);
    bus2.start = 1'b0;
    for (int k = 0; k < 100 && q2.size() > 0; k++) @(negedge clk);
    if (q2.size() > 0) begin
      check("timeout2", q2.size(), 0);
      q2.delete();
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
